// File: rtl/ttl_decoder_seq.sv
// Registered-address 1-of-WIDTH_OUT decoder with load/step sequencer and wrap pulse.
// Optional macro TTL_DECSEQ_PROP_DELAY_EN adds rise/fall delay on Y.
module ttl_decoder_seq #(
  parameter int WIDTH_OUT  = 8,
  parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
  parameter int DELAY_RISE = 20,
  parameter int DELAY_FALL = 20
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Enable1_bar,
  input  logic                 Enable2_bar,
  input  logic                 Enable3,
  input  logic                 Mode,
  input  logic                 Load,
  input  logic                 Step,
  input  logic [WIDTH_IN-1:0]  A,
  input  logic [WIDTH_IN-1:0]  Last,
  output logic [WIDTH_OUT-1:0] Y,
  output logic [WIDTH_IN-1:0]  Index,
  output logic                 Wrap
);

  localparam logic [WIDTH_IN-1:0] MAX_IDX = WIDTH_IN'(WIDTH_OUT - 1);

  if (WIDTH_OUT < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_param_check
    $error("ttl_decoder_seq: WIDTH_OUT must be >= 2 and delays non-negative");
  end

  logic                 enabled;
  logic [WIDTH_IN-1:0]  last_eff;
  logic [WIDTH_IN-1:0]  addr;
  logic                 wrap_q;
  logic [WIDTH_OUT-1:0] y_dec;

  assign enabled  = !Enable1_bar && !Enable2_bar && Enable3;
  // Out-of-range terminal indices collapse onto the highest real output.
  assign last_eff = (Last > MAX_IDX) ? MAX_IDX : Last;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr   <= '0;
      wrap_q <= 1'b0;
    end else if (Load) begin
      addr   <= A;
      wrap_q <= 1'b0;
    end else if (Mode && Step && enabled) begin
      if (addr >= last_eff) begin
        addr   <= '0;
        wrap_q <= 1'b1;
      end else begin
        addr   <= addr + 1'b1;
        wrap_q <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  // Addresses beyond WIDTH_OUT-1 match no output, so Y goes all-zero.
  always_comb begin
    y_dec = '0;
    for (int i = 0; i < WIDTH_OUT; i++) begin
      y_dec[i] = enabled && (addr == i[WIDTH_IN-1:0]);
    end
  end

  assign Index = addr;
  assign Wrap  = wrap_q;

`ifdef TTL_DECSEQ_PROP_DELAY_EN
  assign #(DELAY_RISE, DELAY_FALL) Y = y_dec;
`else
  assign Y = y_dec;
`endif

endmodule

// File: tb/tb_ttl_decoder_seq.sv
// Scoreboard bench for ttl_decoder_seq: an 8-output and a 6-output instance share
// the stimulus; expectations are queued per cycle and checked by a monitor.
`timescale 1ns/1ps
module tb_ttl_decoder_seq;

  typedef struct {
    bit         sel;
    logic [2:0] idx;
    logic [7:0] y;
    logic       wrap;
    string      name;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       enable1_bar, enable2_bar, enable3;
  logic       mode, load, step;
  logic [2:0] a, last;
  logic [7:0] y8;
  logic [2:0] index8;
  logic       wrap8;
  logic [5:0] y6;
  logic [2:0] index6;
  logic       wrap6;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  ttl_decoder_seq #(.WIDTH_OUT(8)) dut8 (
    .Clk(clk), .Reset(reset), .Enable1_bar(enable1_bar), .Enable2_bar(enable2_bar),
    .Enable3(enable3), .Mode(mode), .Load(load), .Step(step), .A(a), .Last(last),
    .Y(y8), .Index(index8), .Wrap(wrap8)
  );

  ttl_decoder_seq #(.WIDTH_OUT(6)) dut6 (
    .Clk(clk), .Reset(reset), .Enable1_bar(enable1_bar), .Enable2_bar(enable2_bar),
    .Enable3(enable3), .Mode(mode), .Load(load), .Step(step), .A(a), .Last(last),
    .Y(y6), .Index(index6), .Wrap(wrap6)
  );

  // Period is long enough that a 20-unit output delay settles before sampling.
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Queue the response expected after the next rising edge, then let the edge happen.
  task automatic apply_stimulus(input bit sel, input logic [2:0] idx, input logic [7:0] y,
                                input logic wrap, input string name);
    exp_t e;
    e.sel = sel; e.idx = idx; e.y = y; e.wrap = wrap; e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.sel == 1'b0) begin
          check_output({e.name, ".index"}, {5'b0, index8}, {5'b0, e.idx});
          check_output({e.name, ".y"},     y8,             e.y);
          check_output({e.name, ".wrap"},  {7'b0, wrap8},  {7'b0, e.wrap});
        end else begin
          check_output({e.name, ".index"}, {5'b0, index6}, {5'b0, e.idx});
          check_output({e.name, ".y"},     {2'b0, y6},     e.y);
          check_output({e.name, ".wrap"},  {7'b0, wrap6},  {7'b0, e.wrap});
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enable1_bar = 1'b0; enable2_bar = 1'b0; enable3 = 1'b1;
    mode = 1'b0; load = 1'b0; step = 1'b0; a = 3'd0; last = 3'd0;
    @(negedge clk);
    #1;

    // Reset and enable gating
    apply_stimulus(0, 3'd0, 8'b0000_0001, 1'b0, "reset");
    reset = 1'b0; enable3 = 1'b0;
    apply_stimulus(0, 3'd0, 8'b0000_0000, 1'b0, "enable3_low");

    // Latched decode
    enable3 = 1'b1; load = 1'b1; a = 3'd5;
    apply_stimulus(0, 3'd5, 8'b0010_0000, 1'b0, "load5");
    load = 1'b0; a = 3'd2;
    apply_stimulus(0, 3'd5, 8'b0010_0000, 1'b0, "a_ignored");
    step = 1'b1;
    apply_stimulus(0, 3'd5, 8'b0010_0000, 1'b0, "step_mode0");

    // Sequencer sweep with Last=3
    step = 1'b0; reset = 1'b1;
    apply_stimulus(0, 3'd0, 8'b0000_0001, 1'b0, "reset2");
    reset = 1'b0; mode = 1'b1; last = 3'd3; step = 1'b1;
    apply_stimulus(0, 3'd1, 8'b0000_0010, 1'b0, "sweep3_1");
    apply_stimulus(0, 3'd2, 8'b0000_0100, 1'b0, "sweep3_2");
    apply_stimulus(0, 3'd3, 8'b0000_1000, 1'b0, "sweep3_3");
    apply_stimulus(0, 3'd0, 8'b0000_0001, 1'b1, "sweep3_wrap");
    apply_stimulus(0, 3'd1, 8'b0000_0010, 1'b0, "sweep3_after");

    // Full 8-state sweep with Last=7
    last = 3'd7;
    apply_stimulus(0, 3'd2, 8'b0000_0100, 1'b0, "sweep7_2");
    apply_stimulus(0, 3'd3, 8'b0000_1000, 1'b0, "sweep7_3");
    apply_stimulus(0, 3'd4, 8'b0001_0000, 1'b0, "sweep7_4");
    apply_stimulus(0, 3'd5, 8'b0010_0000, 1'b0, "sweep7_5");
    apply_stimulus(0, 3'd6, 8'b0100_0000, 1'b0, "sweep7_6");
    apply_stimulus(0, 3'd7, 8'b1000_0000, 1'b0, "sweep7_7");
    apply_stimulus(0, 3'd0, 8'b0000_0001, 1'b1, "sweep7_wrap");
    apply_stimulus(0, 3'd1, 8'b0000_0010, 1'b0, "sweep7_after");

    // Loaded value above LastEff wraps on the next step
    last = 3'd3; step = 1'b0; load = 1'b1; a = 3'd6;
    apply_stimulus(0, 3'd6, 8'b0100_0000, 1'b0, "load6");
    load = 1'b0; step = 1'b1;
    apply_stimulus(0, 3'd0, 8'b0000_0001, 1'b1, "over_last_wrap");

    // Step ignored while disabled
    enable1_bar = 1'b1;
    apply_stimulus(0, 3'd0, 8'b0000_0000, 1'b0, "step_disabled");
    enable1_bar = 1'b0;

    // Load beats Step
    step = 1'b0; load = 1'b1; a = 3'd3;
    apply_stimulus(0, 3'd3, 8'b0000_1000, 1'b0, "load3");
    a = 3'd4; step = 1'b1;
    apply_stimulus(0, 3'd4, 8'b0001_0000, 1'b0, "load_over_step");

    // Reset beats Load
    reset = 1'b1; a = 3'd6; step = 1'b0;
    apply_stimulus(0, 3'd0, 8'b0000_0001, 1'b0, "reset_over_load");
    reset = 1'b0; load = 1'b0; step = 1'b1;
    apply_stimulus(0, 3'd1, 8'b0000_0010, 1'b0, "pre_wrap_1");
    apply_stimulus(0, 3'd2, 8'b0000_0100, 1'b0, "pre_wrap_2");
    apply_stimulus(0, 3'd3, 8'b0000_1000, 1'b0, "pre_wrap_3");
    reset = 1'b1;
    apply_stimulus(0, 3'd0, 8'b0000_0001, 1'b0, "reset_at_wrap");

    // Back-to-back wraps with LastEff=0
    reset = 1'b0; last = 3'd0;
    apply_stimulus(0, 3'd0, 8'b0000_0001, 1'b1, "b2b_wrap_1");
    apply_stimulus(0, 3'd0, 8'b0000_0001, 1'b1, "b2b_wrap_2");
    mode = 1'b0;
    apply_stimulus(0, 3'd0, 8'b0000_0001, 1'b0, "mode_change");

    // Six-output instance: Last clamps to 5
    step = 1'b0; reset = 1'b1;
    apply_stimulus(1, 3'd0, 8'b0000_0001, 1'b0, "w6_reset");
    reset = 1'b0; mode = 1'b1; last = 3'd7; step = 1'b1;
    apply_stimulus(1, 3'd1, 8'b0000_0010, 1'b0, "w6_1");
    apply_stimulus(1, 3'd2, 8'b0000_0100, 1'b0, "w6_2");
    apply_stimulus(1, 3'd3, 8'b0000_1000, 1'b0, "w6_3");
    apply_stimulus(1, 3'd4, 8'b0001_0000, 1'b0, "w6_4");
    apply_stimulus(1, 3'd5, 8'b0010_0000, 1'b0, "w6_5");
    apply_stimulus(1, 3'd0, 8'b0000_0001, 1'b1, "w6_wrap");
    step = 1'b0; load = 1'b1; a = 3'd7;
    apply_stimulus(1, 3'd7, 8'b0000_0000, 1'b0, "w6_load7");
    load = 1'b0; step = 1'b1;
    apply_stimulus(1, 3'd0, 8'b0000_0001, 1'b1, "w6_load7_wrap");

    step = 1'b0;
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
